lead_one_scanner: RTL and testbench

- Sequential leading-one locator for an N-bit word.
- Inverse of the OR-reduction path: the reducer collapses a vector to a single "any bit set" flag; this block recovers *where* the highest set bit is.
- Scans MSB→LSB, one bit per clock, with early termination and a start/busy/done handshake.
- Sits beside the reduction/compare datapath; used by normalisation and max-select control logic.

---
 rtl/lead_one_scanner_pkg.sv | 19 +
 rtl/lead_one_scanner_shift_reg.sv | 43 ++++
 rtl/lead_one_scanner.sv | 141 ++++++++++++++
 tb/tb_lead_one_scanner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/lead_one_scanner_pkg.sv
// Shared definitions for the leading-one scanner slice.
//   - los_state_t   : controller state encoding (IDLE / SCAN / DONE)
//   - LOS_DEFAULT_N : default scanned word width
//   - los_idx_w()   : width of an index able to address every bit of an N-bit word
package lead_one_scanner_pkg;

    localparam int LOS_DEFAULT_N = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } los_state_t;

    function automatic int los_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lead_one_scanner_shift_reg.sv
// scan_shift_reg: N-bit loadable left-shift register exposing its MSB.
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset, clears the register
//   load_i  : load data_i (has priority over shift_i)
//   shift_i : shift left by one, zero fill
//   data_i  : parallel load value
//   msb_o   : current bit N-1
module scan_shift_reg
    import lead_one_scanner_pkg::*;
#(
    parameter int N = LOS_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [N-1:0] data_i,
    output logic         msb_o
);

    logic [N-1:0] sreg_q;
    logic [N-1:0] sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (load_i) begin
            sreg_d = data_i;
        end else if (shift_i) begin
            sreg_d = {sreg_q[N-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign msb_o = sreg_q[N-1];

endmodule

// File: rtl/lead_one_scanner.sv
// lead_one_scanner: sequential leading-one locator, scanning MSB to LSB one
// bit per clock with early termination and a start/busy/done handshake.
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset
//   start   : request, sampled only in IDLE
//   data_in : word to scan, captured on the accepted start edge
//   busy    : high in SCAN and DONE
//   done    : one-cycle pulse, results valid from this cycle
//   found   : a set bit exists
//   zero    : scanned word was all-zero
//   index   : position of the highest set bit (0 when zero=1)
// Build option: define ZERO_SHORTCUT_EN to finish an all-zero word directly
// from IDLE to DONE instead of scanning every bit.
module lead_one_scanner
    import lead_one_scanner_pkg::*;
#(
    parameter  int N     = LOS_DEFAULT_N,
    localparam int IDX_W = los_idx_w(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N-1:0]     data_in,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             zero,
    output logic [IDX_W-1:0] index
);

    los_state_t       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             found_q, found_d;
    logic             zero_q, zero_d;
    logic             load, shift, msb;
    logic             accept;
    logic             any_set;

    // OR-reduction of the incoming word; only consulted by the shortcut path.
    assign any_set = |data_in;
    assign accept  = (state_q == IDLE) && start;

    scan_shift_reg #(.N(N)) u_sreg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .shift_i(shift),
        .data_i (data_in),
        .msb_o  (msb)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef ZERO_SHORTCUT_EN
                    state_d = any_set ? SCAN : DONE;
`else
                    state_d = SCAN;
`endif
                end
            end
            SCAN: begin
                if (msb || (cnt_q == '0)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Scan datapath: counter tracks the bit position currently at the MSB.
    always_comb begin
        cnt_d   = cnt_q;
        index_d = index_q;
        found_d = found_q;
        zero_d  = zero_q;
        load    = accept;
        shift   = 1'b0;
        if (accept) begin
            cnt_d   = IDX_W'(N - 1);
            index_d = '0;
            found_d = 1'b0;
            zero_d  = 1'b0;
`ifdef ZERO_SHORTCUT_EN
            zero_d  = !any_set;
`endif
        end else if (state_q == SCAN) begin
            if (msb) begin
                index_d = cnt_q;
                found_d = 1'b1;
                zero_d  = 1'b0;
            end else if (cnt_q == '0) begin
                index_d = '0;
                found_d = 1'b0;
                zero_d  = 1'b1;
            end else begin
                shift = 1'b1;
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            index_q <= '0;
            found_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            index_q <= index_d;
            found_q <= found_d;
            zero_q  <= zero_d;
        end
    end

    assign found = found_q;
    assign zero  = zero_q;
    assign index = index_q;

endmodule

// File: tb/tb_lead_one_scanner.sv
// Self-checking bench for lead_one_scanner (N=32): stimulus pushes the
// expected result and done cycle into a scoreboard queue; a monitor pops and
// compares when done is seen, and checks busy/held outputs every cycle.
module tb_lead_one_scanner;

    localparam int N  = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  data_in;
    logic          busy, done, found, zero;
    logic [IW-1:0] index;

    lead_one_scanner #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .data_in(data_in),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .zero   (zero),
        .index  (index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            start_cyc;
        int            done_cyc;
        logic          found;
        logic          zero;
        logic [IW-1:0] index;
    } exp_t;

    exp_t          sb[$];
    logic          hold_found = 1'b0;
    logic          hold_zero  = 1'b0;
    logic [IW-1:0] hold_index = '0;
    int            errs   = 0;
    int            checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: highest set bit found by plain search; latency from the
    // number of bit positions visited plus the DONE cycle.
    function automatic exp_t model(input logic [N-1:0] d, input int c);
        exp_t e;
        int   p = -1;
        int   lat;
        for (int i = 0; i < N; i++) if (d[i]) p = i;
        e.start_cyc = c;
        if (p < 0) begin
            e.found = 1'b0;
            e.zero  = 1'b1;
            e.index = '0;
`ifdef ZERO_SHORTCUT_EN
            lat = 1;
`else
            lat = N + 1;
`endif
        end else begin
            e.found = 1'b1;
            e.zero  = 1'b0;
            e.index = IW'(p);
            lat     = N - p + 1;
        end
        e.done_cyc = c + lat;
        return e;
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
                checks++;
                errs++;
                $display("FAIL done_missing: got no done, required done at cycle %0d", sb[0].done_cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && cyc > sb[0].start_cyc) begin
                check("busy_inflight", busy, 1);
                if (cyc == sb[0].done_cyc) begin
                    check("done_pulse", done, 1);
                    check("found", found, sb[0].found);
                    check("zero", zero, sb[0].zero);
                    check("index", index, sb[0].index);
                    hold_found = sb[0].found;
                    hold_zero  = sb[0].zero;
                    hold_index = sb[0].index;
                    void'(sb.pop_front());
                end else begin
                    check("done_early", done, 0);
                    check("found_cleared", found, 0);
                    check("zero_cleared", zero, 0);
                    check("index_cleared", index, 0);
                end
            end else begin
                check("busy_idle", busy, 0);
                check("done_idle", done, 0);
                check("found_hold", found, hold_found);
                check("zero_hold", zero, hold_zero);
                check("index_hold", index, hold_index);
            end
        end
    end

    // Issue one accepted start, then jitter start/data_in while busy,
    // including a start during the DONE cycle, all of which must be ignored.
    task automatic run(input logic [N-1:0] d, input int gap);
        exp_t e;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            start   = 1'b0;
            data_in = $urandom;
        end
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        e = model(d, cyc);
        sb.push_back(e);
        for (int k = 1; k <= e.done_cyc - e.start_cyc; k++) begin
            @(negedge clk);
            start   = (k == e.done_cyc - e.start_cyc) ? 1'b1 : 1'($urandom_range(0, 1));
            data_in = $urandom;
        end
    endtask

    task automatic run_abort(input logic [N-1:0] d, input int rst_at);
        exp_t e;
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        e = model(d, cyc);
        sb.push_back(e);
        for (int k = 1; k < rst_at; k++) begin
            @(negedge clk);
            start   = 1'($urandom_range(0, 1));
            data_in = $urandom;
        end
        @(negedge clk);
        rst_n      = 1'b0;
        start      = 1'b1;
        sb.delete();
        hold_found = 1'b0;
        hold_zero  = 1'b0;
        hold_index = '0;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] d;
        rst_n   = 1'b0;
        start   = 1'b1;
        data_in = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);

        run(32'h8000_0000, 0);
        run(32'h0000_0001, 0);
        run(32'h0001_0F00, 1);
        run(32'h0000_0000, 0);
        run_abort(32'h0000_0004, 10);
        run(32'h4000_0000, 0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 7) == 0) d = '0;
            else d = $urandom >> $urandom_range(0, 31);
            run(d, $urandom_range(0, 2));
        end

        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
